// File: rtl/axis_distributor_pkg.sv
// Shared constants and helpers for the 1-to-2 AXI4-Stream distributor.
package axis_distributor_pkg;

  // Router FSM encodings.
  localparam logic STATE_RUN   = 1'b0;
  localparam logic STATE_DRAIN = 1'b1;

  // Each output stage holds at most this many words.
  localparam logic [1:0] BUF_DEPTH = 2'd2;

  // Saturating occupancy update: +1 on push, -1 on pop, clamped to [0, BUF_DEPTH].
  function automatic logic [1:0] occ_next(input logic [1:0] occ,
                                          input logic       push,
                                          input logic       pop);
    logic [1:0] r;
    r = occ;
    case ({push, pop})
      2'b10:   r = (occ >= BUF_DEPTH) ? BUF_DEPTH : occ + 2'd1;
      2'b01:   r = (occ == 2'd0) ? 2'd0 : occ - 2'd1;
      default: r = occ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/axis_distributor_inout_buffer.sv
// Registered handshake stage: 2-entry skid buffer with a registered in_ready.
// A word accepted at edge N is presented on the output from edge N.
module inout_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  logic                  main_valid_q, main_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q,  main_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
  logic                  in_ready_q,   in_ready_d;
  logic                  push, pop;

  assign push        = in_valid_i & in_ready_q;
  assign pop         = main_valid_q & out_ready_i;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

  // Next-state: the output register refills from the skid slot first to keep order.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = push;
        if (push) skid_data_d = in_data_i;
      end else begin
        main_valid_d = push;
        if (push) main_data_d = in_data_i;
      end
    end else if (push) begin
      // in_ready_q guarantees the skid slot is free here.
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
    // Ready for another word as long as the skid slot stays free.
    in_ready_d = ~skid_valid_d;
  end

  // State registers; in_ready stays low while in reset and rises one edge after.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

endmodule

// File: rtl/axis_distributor.sv
// 1-to-2 AXI4-Stream router. The slave stream is steered to m00 or m01 by
// cfg_data; a select change drains the old output completely before any word
// is accepted for the new one, so the global output order matches input order.
module axis_distributor
  import axis_distributor_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_data,
  output logic                        sts_data,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                        m00_axis_tvalid,
  input  logic                        m00_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m01_axis_tdata,
  output logic                        m01_axis_tvalid,
  input  logic                        m01_axis_tready
);

  logic            state_q, state_d;
  logic            sel_q, sel_d;
  logic [1:0]      stg_in_valid;
  logic [1:0]      stg_in_ready;
  logic [1:0]      stg_out_valid;
  logic [1:0]      stg_out_ready;
  logic [1:0][1:0] occ_q, occ_d;
  logic            old_empty;

  assign sts_data      = sel_q;
  assign stg_out_ready = {m01_axis_tready, m00_axis_tready};
  assign m00_axis_tvalid = stg_out_valid[0];
  assign m01_axis_tvalid = stg_out_valid[1];

  // Steering: only the applied output sees the slave stream, and only in RUN.
  // The raw cfg_data is deliberately not used here, so a word presented on the
  // edge where cfg_data changes still lands on the old output.
  always_comb begin
    stg_in_valid  = 2'b00;
    s_axis_tready = 1'b0;
    if (state_q == STATE_RUN) begin
      stg_in_valid[sel_q] = s_axis_tvalid;
      s_axis_tready       = stg_in_ready[sel_q];
    end
  end

  inout_buffer #(.DATA_WIDTH(AXIS_TDATA_WIDTH)) buf_0 (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .in_data_i   (s_axis_tdata),
    .in_valid_i  (stg_in_valid[0]),
    .in_ready_o  (stg_in_ready[0]),
    .out_data_o  (m00_axis_tdata),
    .out_valid_o (stg_out_valid[0]),
    .out_ready_i (stg_out_ready[0])
  );

  inout_buffer #(.DATA_WIDTH(AXIS_TDATA_WIDTH)) buf_1 (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .in_data_i   (s_axis_tdata),
    .in_valid_i  (stg_in_valid[1]),
    .in_ready_o  (stg_in_ready[1]),
    .out_data_o  (m01_axis_tdata),
    .out_valid_o (stg_out_valid[1]),
    .out_ready_i (stg_out_ready[1])
  );

  // Occupancy tracking per stage: the buffer does not export its fill level.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      occ_d[k] = occ_next(occ_q[k],
                          stg_in_valid[k] & stg_in_ready[k],
                          stg_out_valid[k] & stg_out_ready[k]);
    end
  end

  // The old output counts as drained only with nothing presented and nothing held.
  assign old_empty = (occ_q[sel_q] == 2'd0) & ~stg_out_valid[sel_q];

  // Next-state: leave RUN on a select mismatch; commit the new select only
  // once the old output is empty. A DRAIN never times out.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (state_q == STATE_RUN) begin
      if (cfg_data != sel_q) state_d = STATE_DRAIN;
    end else begin
      if (cfg_data == sel_q) begin
        state_d = STATE_RUN;
      end else if (old_empty) begin
        state_d = STATE_RUN;
        sel_d   = cfg_data;
      end
    end
  end

  // Control registers; reset discards any in-flight switch.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= STATE_RUN;
      sel_q   <= 1'b0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      occ_q   <= occ_d;
    end
  end

endmodule

// File: doc/axis_distributor.md
Name: axis_distributor

Overview:
- 1-to-2 AXI4-Stream router; the inverse of the 2-to-1 stream selector.
- Steers one slave stream to m00 or m01 under cfg_data.
- Each output is decoupled by its own registered handshake stage.
- Select changes are made hazard-free: the old output is drained before traffic moves to the new one, so words never reorder across outputs and no word is lost or duplicated.

Parameters:
- AXIS_TDATA_WIDTH, 32, width of every tdata bus.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, asynchronous assert, active-low.
- cfg_data  in  1  requested output (0 = m00, 1 = m01); quasi-static, may change at any cycle.
- sts_data  out  1  currently applied select (int_sel_reg).
- s_axis_tdata  in  AXIS_TDATA_WIDTH  input data.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m00_axis_tdata  out  AXIS_TDATA_WIDTH  output 0 data.
- m00_axis_tvalid  out  1  output 0 valid.
- m00_axis_tready  in  1  output 0 ready.
- m01_axis_tdata  out  AXIS_TDATA_WIDTH  output 1 data.
- m01_axis_tvalid  out  1  output 1 valid.
- m01_axis_tready  in  1  output 1 ready.

Behaviour:
- Reset (async, aresetn=0):
  - int_sel_reg=0, state=RUN.
  - Both output stages empty: m00/m01_axis_tvalid=0, tdata=0.
  - s_axis_tready=0 while aresetn=0.
  - Reset mid-transfer discards all buffered words.
- Output stage contract (per output): 2-entry skid buffer.
  - in_ready is registered and high while the buffer holds fewer than 2 words.
  - A word accepted at edge N gives out_valid=1 from edge N (visible in cycle N+1), so latency is 1 cycle.
  - Sustains 1 word/cycle with out_ready held high.
  - Order is preserved.
- Routing in RUN with cfg_data==int_sel_reg:
  - Selected stage in_valid = s_axis_tvalid; other stage in_valid=0.
  - s_axis_tready = selected stage in_ready.
  - Transfer occurs when s_axis_tvalid & s_axis_tready.
- FSM states: RUN, DRAIN.
  - RUN -> DRAIN when cfg_data != int_sel_reg, sampled at the edge. A transfer at that same edge still completes to the old output.
  - In DRAIN, s_axis_tready=0 and no word is accepted.
  - DRAIN -> RUN on the edge where the old output's stage is empty (out_valid=0 and no word held). On that edge int_sel_reg <= cfg_data.
  - If cfg_data returns to int_sel_reg during DRAIN, go back to RUN at the next edge without changing the select.
  - Minimum switch penalty: 1 dead cycle with the old output empty. Otherwise it is the drain time plus 1.
- The inactive output may still hold words while draining in parallel. Only the old selected output gates the switch.
- A stalled old output (tready=0 forever) keeps DRAIN forever. This is required, never time out.
- sts_data = int_sel_reg and changes only on the DRAIN -> RUN edge.

Decomposition:
- Shared package: no typedefs needed. FSM state encodings RUN=1'b0 and DRAIN=1'b1 are localparams.
- Sub-module: inout_buffer (DATA_WIDTH=AXIS_TDATA_WIDTH), the codebase's existing registered handshake stage, instantiated twice (buf_0 for m00, buf_1 for m01).
- Top level holds int_sel_reg, the FSM and the steering logic, plus a per-stage "holds data" indication. If inout_buffer does not export occupancy, track it with a 2-bit counter per output. The counter increments on accept, decrements on out handshake, and is never above 2 or below 0.

Test Plan:
- Reset/idle: aresetn=0 for 5 cycles with s_axis_tvalid=1 -> all tvalid=0, s_axis_tready=0, sts_data=0. Release -> s_axis_tready=1 within 2 cycles.
- Streaming m00: cfg_data=0, send 0x1..0x10 back-to-back with m00_axis_tready=1 -> m00 emits 0x1..0x10 in order at 1 word/cycle, 1-cycle latency; m01_axis_tvalid stays 0.
- Switch with backlog: m00_axis_tready=0, send 0xA,0xB, set cfg_data=1, send 0xC pending -> s_axis_tready=0, sts_data=0. Raise m00_axis_tready -> m00 emits 0xA,0xB, then sts_data=1, then 0xC appears on m01 only.
- Aborted switch: cfg_data pulses 0->1->0 for one cycle with m00 holding 1 word -> sts_data stays 0, traffic resumes on m00, no word is lost.
- Random backpressure: 1000 random words, random tready on both outputs, cfg_data toggled every ~50 cycles -> the concatenated per-output streams match the scoreboard of the input sequence split at each applied switch, with no loss or duplication.
- Reset mid-drain: assert aresetn during DRAIN with 2 words buffered -> outputs invalid immediately, sts_data=0, and the buffered words are never emitted.
